// File: rtl/jpc_regfile_mp.sv
// ----------------------------------------------------------------------------
// jpc_regfile_mp -- multi-port JPC register file.
//
// One write channel (writeback) and NRD independent read channels (decode /
// issue), all with valid/ready handshakes. Each read channel owns a one-entry
// registered output slot: data appears the cycle after the request is
// accepted and is held stable while the consumer stalls.
//
// Register 0 always reads as zero. Indices >= NREGS read as zero, are never
// written, and set the sticky err_O flag (cleared only by rst).
//
// Optional feature, macro JPC_REGFILE_BYPASS_EN:
//   defined   -> a read accepted in the same cycle as a write fire to the same
//                nonzero in-range index loads the incoming write data.
//   undefined -> that read loads the old register contents.
// ----------------------------------------------------------------------------
module jpc_regfile_mp #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int IDX_W  = 5,
   parameter int NRD    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD-1:0]        rd_idx_valid_I,
   input  logic [NRD*IDX_W-1:0]  rd_idx_I,
   output logic [NRD-1:0]        rd_idx_ready_O,
   output logic [NRD*DATA_W-1:0] rd_data_O,
   output logic [NRD-1:0]        rd_data_valid_O,
   input  logic [NRD-1:0]        rd_data_ready_I,
   input  logic                  wr_valid_I,
   input  logic [IDX_W-1:0]      wr_idx_I,
   input  logic [DATA_W-1:0]     wr_data_I,
   output logic                  wr_ready_O,
   output logic                  err_O
);

   // Architectural state and per-channel output slots.
   logic [DATA_W-1:0] regs_q     [NREGS];
   logic [DATA_W-1:0] regs_d     [NREGS];
   logic [DATA_W-1:0] rd_data_q  [NRD];
   logic [DATA_W-1:0] rd_data_d  [NRD];
   logic [IDX_W-1:0]  rd_idx     [NRD];
   logic [NRD-1:0]    rd_valid_q;
   logic [NRD-1:0]    rd_valid_d;
   logic [NRD-1:0]    rd_accept;
   logic              wr_ready_q;
   logic              wr_fire;
   logic              err_q;
   logic              err_d;

   // An index addresses a real register only when it is below NREGS.
   function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
      return 32'(idx) < 32'(NREGS);
   endfunction

   assign wr_fire = wr_valid_I && wr_ready_q;

   // Unpack the per-channel read indices and compute the request handshakes.
   always_comb begin
      for (int k = 0; k < NRD; k++) begin
         rd_idx[k]    = rd_idx_I[k*IDX_W +: IDX_W];
         rd_accept[k] = rd_idx_valid_I[k] && (!rd_valid_q[k] || rd_data_ready_I[k]);
      end
      rd_idx_ready_O = ~rd_valid_q | rd_data_ready_I;
   end

   // Next state of every read slot: load on accept, empty on drain, else hold.
   always_comb begin
      // NOTE: every variable assigned in this block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      rd_valid_d = rd_valid_q;
      for (int k = 0; k < NRD; k++) begin
         rd_data_d[k] = rd_data_q[k];
         if (rd_accept[k]) begin
            // Register 0 and out-of-range indices match no entry and load 0.
            rd_data_d[k] = '0;
            for (int r = 1; r < NREGS; r++) begin
               if (rd_idx[k] == IDX_W'(r)) begin
                  rd_data_d[k] = regs_q[r];
               end
            end
`ifdef JPC_REGFILE_BYPASS_EN
            // Forward a same-cycle write so the reader sees the new value.
            if (wr_fire && (wr_idx_I == rd_idx[k]) && (wr_idx_I != '0) &&
                idx_in_range(wr_idx_I)) begin
               rd_data_d[k] = wr_data_I;
            end
`endif
            rd_valid_d[k] = 1'b1;
         end else if (rd_valid_q[k] && rd_data_ready_I[k]) begin
            rd_valid_d[k] = 1'b0;
         end
      end
   end

   // Next state of the register array; register 0 stays hardwired to zero.
   always_comb begin
      regs_d    = regs_q;
      regs_d[0] = '0;
      for (int r = 1; r < NREGS; r++) begin
         if (wr_fire && (wr_idx_I == IDX_W'(r))) begin
            regs_d[r] = wr_data_I;
         end
      end
   end

   // Sticky error: any fired write or accepted read with an out-of-range index.
   always_comb begin
      err_d = err_q;
      if (wr_fire && !idx_in_range(wr_idx_I)) begin
         err_d = 1'b1;
      end
      for (int k = 0; k < NRD; k++) begin
         if (rd_accept[k] && !idx_in_range(rd_idx[k])) begin
            err_d = 1'b1;
         end
      end
   end

   // State registers; rst clears everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the register array is reset too, because the core relies on
         // every register reading 0 after rst; this keeps it out of RAM.
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
         for (int k = 0; k < NRD; k++) begin
            rd_data_q[k] <= '0;
         end
         rd_valid_q <= '0;
         wr_ready_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // pre-edge values regardless of statement order.
         regs_q     <= regs_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         wr_ready_q <= 1'b1;
         err_q      <= err_d;
      end
   end

   // Pack the slot contents onto the flat output buses.
   always_comb begin
      rd_data_O = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_data_O[k*DATA_W +: DATA_W] = rd_data_q[k];
      end
   end

   assign rd_data_valid_O = rd_valid_q;
   assign wr_ready_O      = wr_ready_q;
   assign err_O           = err_q;

endmodule

// File: tb/tb_jpc_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_jpc_regfile_mp -- self-checking bench for jpc_regfile_mp.
// DUT built with NREGS=16, IDX_W=5 so out-of-range indices are reachable, and
// NRD=3 so multi-channel behaviour is exercised. The reference model works on
// whole transactions per clock edge: a register array, a sticky error bit and
// one (valid, data) slot per channel. Follows JPC_REGFILE_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_jpc_regfile_mp;

   localparam int DW  = 32;
   localparam int NR  = 16;
   localparam int IW  = 5;
   localparam int NRD = 3;
`ifdef JPC_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD-1:0]    rv;
   logic [NRD*IW-1:0] ridx;
   logic [NRD-1:0]    rrdy_o;
   logic [NRD*DW-1:0] rdata_o;
   logic [NRD-1:0]    rvalid_o;
   logic [NRD-1:0]    rrdy;
   logic              wv;
   logic [IW-1:0]     widx;
   logic [DW-1:0]     wd;
   logic              wrdy_o;
   logic              err_o;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [DW-1:0] m_regs [2**IW];
   logic [DW-1:0] m_sd   [NRD];
   bit            m_sv   [NRD];
   bit            m_err;
   bit            m_wr_rdy;

   always #5 clk = ~clk;

   jpc_regfile_mp #(.DATA_W(DW), .NREGS(NR), .IDX_W(IW), .NRD(NRD)) dut (
      .clk             (clk),
      .rst             (rst),
      .rd_idx_valid_I  (rv),
      .rd_idx_I        (ridx),
      .rd_idx_ready_O  (rrdy_o),
      .rd_data_O       (rdata_o),
      .rd_data_valid_O (rvalid_o),
      .rd_data_ready_I (rrdy),
      .wr_valid_I      (wv),
      .wr_idx_I        (widx),
      .wr_data_I       (wd),
      .wr_ready_O      (wrdy_o),
      .err_O           (err_o)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2**IW; i++) m_regs[i] = '0;
      for (int k = 0; k < NRD; k++) begin
         m_sv[k] = 1'b0;
         m_sd[k] = '0;
      end
      m_err    = 1'b0;
      m_wr_rdy = 1'b0;
   endtask

   // Apply one clock edge worth of transactions to the model (pre-edge inputs).
   task automatic model_edge();
      bit            wf;
      logic [IW-1:0] idx;
      wf = wv && m_wr_rdy;
      for (int k = 0; k < NRD; k++) begin
         idx = ridx[k*IW +: IW];
         if (rv[k] && (!m_sv[k] || rrdy[k])) begin
            if (int'(idx) >= NR) begin
               m_sd[k] = '0;
               m_err   = 1'b1;
            end else if (idx == '0) begin
               m_sd[k] = '0;
            end else if (BYP && wf && widx == idx) begin
               m_sd[k] = wd;
            end else begin
               m_sd[k] = m_regs[idx];
            end
            m_sv[k] = 1'b1;
         end else if (m_sv[k] && rrdy[k]) begin
            m_sv[k] = 1'b0;
         end
      end
      if (wf) begin
         if (int'(widx) >= NR) m_err = 1'b1;
         else if (widx != '0)  m_regs[widx] = wd;
      end
      m_wr_rdy = 1'b1;
   endtask

   task automatic check_outs(input string tag);
      for (int k = 0; k < NRD; k++) begin
         check($sformatf("%s.valid%0d", tag, k), 32'(rvalid_o[k]), 32'(m_sv[k]));
         check($sformatf("%s.data%0d", tag, k), rdata_o[k*DW +: DW], m_sd[k]);
      end
      check({tag, ".err"}, 32'(err_o), 32'(m_err));
      check({tag, ".wr_ready"}, 32'(wrdy_o), 32'(m_wr_rdy));
   endtask

   // One cycle: check request-ready, take the edge, check registered outputs.
   task automatic tick(input string tag);
      #1;
      for (int k = 0; k < NRD; k++) begin
         check($sformatf("%s.rdy%0d", tag, k), 32'(rrdy_o[k]), 32'(!m_sv[k] || rrdy[k]));
      end
      @(posedge clk);
      model_edge();
      #1;
      check_outs(tag);
   endtask

   task automatic idle();
      rv   = '0;
      ridx = '0;
      rrdy = '1;
      wv   = 1'b0;
      widx = '0;
      wd   = '0;
   endtask

   task automatic set_rd(input int k, input bit v, input logic [IW-1:0] idx, input bit rdy);
      rv[k]             = v;
      ridx[k*IW +: IW]  = idx;
      rrdy[k]           = rdy;
   endtask

   task automatic set_wr(input bit v, input logic [IW-1:0] idx, input logic [DW-1:0] d);
      wv   = v;
      widx = idx;
      wd   = d;
   endtask

   initial begin
      // Reset state.
      idle();
      rst = 1'b1;
      model_reset();
      #1;
      check_outs("rst_async");
      repeat (2) @(posedge clk);
      #1;
      check_outs("rst_hold");
      rst = 1'b0;
      tick("first_edge");

      // Write idx 5, read it back on ch0 with one-cycle latency.
      set_wr(1'b1, 5'd5, 32'hDEADBEEF);
      tick("wr5");
      set_wr(1'b0, '0, '0);
      set_rd(0, 1'b1, 5'd5, 1'b1);
      tick("rd5");
      check("rd5.explicit_data", rdata_o[0 +: DW], 32'hDEADBEEF);
      check("rd5.explicit_valid", 32'(rvalid_o[0]), 32'd1);
      set_rd(0, 1'b0, '0, 1'b1);
      tick("rd5_drain");

      // Writes to index 0 are dropped; all channels read 0 from it.
      set_wr(1'b1, 5'd0, 32'h0000_1234);
      tick("wr0");
      set_wr(1'b0, '0, '0);
      for (int k = 0; k < NRD; k++) set_rd(k, 1'b1, 5'd0, 1'b1);
      tick("rd0_all");
      for (int k = 0; k < NRD; k++)
         check($sformatf("rd0.explicit_data%0d", k), rdata_o[k*DW +: DW], 32'h0);
      check("rd0.explicit_err", 32'(err_o), 32'd0);
      idle();
      tick("rd0_drain");

      // Stall on ch1 while the source register is overwritten.
      set_wr(1'b1, 5'd3, 32'h11);
      tick("wr3");
      set_wr(1'b1, 5'd7, 32'h55);
      tick("wr7");
      set_wr(1'b0, '0, '0);
      set_rd(1, 1'b1, 5'd3, 1'b0);
      tick("stall_load");
      check("stall.load_data", rdata_o[DW +: DW], 32'h11);
      for (int c = 0; c < 4; c++) begin
         if (c == 0) set_wr(1'b1, 5'd3, 32'h22);
         else        set_wr(1'b0, '0, '0);
         #1;
         check($sformatf("stall%0d.ready1", c), 32'(rrdy_o[1]), 32'd0);
         tick($sformatf("stall%0d", c));
         check($sformatf("stall%0d.held", c), rdata_o[DW +: DW], 32'h11);
         check($sformatf("stall%0d.valid1", c), 32'(rvalid_o[1]), 32'd1);
      end
      set_rd(1, 1'b0, 5'd3, 1'b1);
      tick("stall_release");
      check("release.valid1", 32'(rvalid_o[1]), 32'd0);
      check("release.data1", rdata_o[DW +: DW], 32'h11);

      // Same-cycle write and read to idx 7.
      set_wr(1'b1, 5'd7, 32'hAA);
      set_rd(0, 1'b1, 5'd7, 1'b1);
      tick("bypass");
      check("bypass.explicit", rdata_o[0 +: DW], BYP ? 32'hAA : 32'h55);
      set_wr(1'b0, '0, '0);
      tick("after_bypass");
      check("after_bypass.explicit", rdata_o[0 +: DW], 32'hAA);
      idle();
      tick("bypass_drain");

      // Out-of-range read and write.
      set_rd(2, 1'b1, 5'd20, 1'b1);
      tick("oor_rd");
      check("oor_rd.data", rdata_o[2*DW +: DW], 32'h0);
      check("oor_rd.err", 32'(err_o), 32'd1);
      idle();
      set_wr(1'b1, 5'd20, 32'hCAFEF00D);
      tick("oor_wr");
      set_wr(1'b0, '0, '0);
      for (int i = 0; i < NR; i++) begin
         set_rd(0, 1'b1, IW'(i), 1'b1);
         tick($sformatf("scan_r%0d", i));
      end
      check("oor.err_sticky", 32'(err_o), 32'd1);
      idle();
      tick("scan_drain");

      // Randomized traffic, including stalls, collisions and bad indices.
      for (int c = 0; c < 400; c++) begin
         set_wr(1'($urandom_range(0, 1)), IW'($urandom_range(0, 31)), $urandom);
         for (int k = 0; k < NRD; k++)
            set_rd(k, 1'($urandom_range(0, 1)), IW'($urandom_range(0, 19)),
                   $urandom_range(0, 3) != 0);
         tick($sformatf("rnd%0d", c));
      end
      idle();
      tick("rnd_drain");

      // Continuous reads on every channel, then reset mid-stream.
      for (int c = 0; c < 6; c++) begin
         for (int k = 0; k < NRD; k++) set_rd(k, 1'b1, IW'($urandom_range(0, NR - 1)), 1'b1);
         tick($sformatf("stream%0d", c));
         for (int k = 0; k < NRD; k++)
            check($sformatf("stream%0d.valid%0d", c, k), 32'(rvalid_o[k]), 32'd1);
      end
      rst = 1'b1;
      model_reset();
      #1;
      check_outs("mid_rst");
      @(posedge clk);
      #1;
      check_outs("mid_rst_hold");
      idle();
      rst = 1'b0;
      tick("post_rst");
      for (int i = 0; i < NR; i += NRD) begin
         for (int k = 0; k < NRD; k++) set_rd(k, 1'b1, IW'((i + k) % NR), 1'b1);
         tick($sformatf("post_scan%0d", i));
         for (int k = 0; k < NRD; k++)
            check($sformatf("post_scan%0d.zero%0d", i, k), rdata_o[k*DW +: DW], 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jpc_regfile_mp.md
Name: jpc_regfile_mp

Overview:
- Parametrised multi-port successor to the JPC register file: one write channel plus NRD independent read channels, each with valid/ready handshakes.
- Each read channel has a registered output slot (1-cycle latency) that holds under back-pressure, so decode can issue several operand reads per cycle and writeback can retire one result per cycle.
- Sits between decode/issue (read channels) and writeback (write channel) in the JPC core.

Parameters:
- DATA_W, 32, register data width in bits.
- NREGS, 32, number of architectural registers (≥2); index 0 hardwired to zero.
- IDX_W, 5, index width; must satisfy 2**IDX_W ≥ NREGS.
- NRD, 2, number of read channels (1..4).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- rd_idx_valid_I  input  NRD  per-channel read request valid.
- rd_idx_I  input  NRD*IDX_W  per-channel read index; channel k at bits [k*IDX_W +: IDX_W].
- rd_idx_ready_O  output  NRD  per-channel request accept.
- rd_data_O  output  NRD*DATA_W  per-channel read data; channel k at bits [k*DATA_W +: DATA_W].
- rd_data_valid_O  output  NRD  per-channel read data valid.
- rd_data_ready_I  input  NRD  per-channel consumer ready.
- wr_valid_I  input  1  write request valid.
- wr_idx_I  input  IDX_W  write index.
- wr_data_I  input  DATA_W  write data.
- wr_ready_O  output  1  write accept.
- err_O  output  1  sticky out-of-range index flag.

Behaviour:
- Reset (async): all regs cleared to 0; rd_data_valid_O = 0; rd_data_O = 0; err_O = 0; wr_ready_O = 0 while rst is high.
- wr_ready_O: 1 from the first clock edge after rst deasserts; it then stays at 1. A write fires when wr_valid_I && wr_ready_O.
- Write fire: regs[wr_idx_I] <= wr_data_I at the edge.
  - Ignored if wr_idx_I == 0.
  - If wr_idx_I ≥ NREGS: write ignored and err_O set to 1.
- Read channel k: two-state slot, EMPTY/FULL, equal to rd_data_valid_O[k].
  - rd_idx_ready_O[k] = !rd_data_valid_O[k] || rd_data_ready_I[k] (combinational; allows back-to-back transfers).
  - Accept: rd_idx_valid_I[k] && rd_idx_ready_O[k]. At the edge, the slot loads the data and rd_data_valid_O[k] <= 1, so data is visible the cycle after acceptance (latency 1).
  - Loaded value: 0 if idx == 0. If idx ≥ NREGS: 0 and err_O set to 1. Otherwise regs[idx], sampled pre-edge.
  - Drain only (valid && ready, no accept): rd_data_valid_O[k] <= 0 and rd_data_O[k] holds its last value.
  - Stall (valid && !ready): rd_data_O[k] and rd_data_valid_O[k] are held stable. Later writes to the same register do not alter held data.
- Channels are fully independent. Any number of channels may read the same index in the same cycle; all receive identical data.
- Same-cycle write fire and read accept to the same nonzero in-range index: the result depends on the optional feature below.
- err_O is cleared only by rst.
- Reset mid-transfer: pending slot data is discarded; no partial write occurs.

Optional Feature:
- Macro: JPC_REGFILE_BYPASS_EN.
- Defined: a read accepted in the same cycle as a write fire to the same nonzero in-range index loads wr_data_I (write-to-read forwarding).
- Undefined: that read loads the old register contents; the new value is visible to reads accepted from the next cycle on.
- Writes to index 0 are never forwarded.

Test Plan:
- Reset then write idx 5 = 0xDEADBEEF, then read ch0 idx 5 → rd_data_O[ch0] = 0xDEADBEEF, valid one cycle after accept.
- Write idx 0 = 0x1234, then read idx 0 on all channels → 0x00000000 on every channel; err_O = 0.
- Ch1 reads idx 3 (= 0x11) with rd_data_ready_I[1] = 0 for 4 cycles while idx 3 is written to 0x22 → data held at 0x11; rd_idx_ready_O[1] = 0 during the stall; one transfer completes on release.
- Same cycle: write idx 7 = 0xAA (previously 0x55) and ch0 reads idx 7 → 0xAA with JPC_REGFILE_BYPASS_EN, 0x55 without.
- NREGS = 16, IDX_W = 5: read idx 20 → data 0 and err_O = 1; write idx 20 → no register changes; err_O stays 1 until rst.
- Continuous reads on all NRD channels with ready held high → one result per channel per cycle. Assert rst mid-stream → all rd_data_valid_O = 0 immediately and all regs read back 0 after release.
